// File: rtl/edge_event_throttle_if.sv
// edge_event_throttle_if: event/acknowledge handshake and status signals of the edge event throttle
interface edge_event_throttle_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 event_i;
  logic                 clear_i;
  logic                 ack_i;
  logic                 edge_o;
  logic                 busy_o;
  logic [CNT_WIDTH-1:0] pending_o;
  logic                 overflow_o;
  logic                 timeout_o;
  modport master (
    output event_i, clear_i, ack_i,
    input  edge_o, busy_o, pending_o, overflow_o, timeout_o
  );
  modport slave (
    input  event_i, clear_i, ack_i,
    output edge_o, busy_o, pending_o, overflow_o, timeout_o
  );
endinterface

// File: rtl/edge_event_throttle.sv
// edge_event_throttle: queues event pulses and replays them one at a time, each after the previous acknowledge (EDGE_THROTTLE_TIMEOUT_EN adds an acknowledge watchdog)
module edge_event_throttle #(
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 clk_i,
  input logic                 rst_i,
  edge_event_throttle_if.slave io
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  state_t               state_q, state_d;
  logic                 ack_q;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 to_q, to_d;
  logic                 ev, ack_rise, work, go, inc, dec, expired;
`ifdef EDGE_THROTTLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // watchdog: cycles spent in WAIT_ACK, zeroed whenever outside it so each wait starts fresh
  always_comb begin
    tmo_d   = (state_q == WAIT_ACK) ? tmo_q + 1'b1 : '0;
    expired = (state_q == WAIT_ACK) && !ack_rise && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    to_d    = io.clear_i ? 1'b0 : (to_q | expired);
  end
  // watchdog register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      to_q  <= to_d;
    end
  end
`else
  assign expired = 1'b0;
  assign to_d    = 1'b0;
  assign to_q    = 1'b0;
`endif
  // next state and pending-count bookkeeping; a coincident event and counter consumption net to zero
  always_comb begin
    ev       = io.event_i & ~io.clear_i;
    ack_rise = io.ack_i & ~ack_q;
    work     = ev | (pend_q != '0);
    state_d  = state_q;
    case (state_q)
      IDLE:     state_d = work ? SEND : IDLE;
      SEND:     state_d = WAIT_ACK;
      WAIT_ACK: state_d = ack_rise ? (work ? SEND : IDLE) : (expired ? IDLE : WAIT_ACK);
      default:  state_d = IDLE;
    endcase
    go     = (state_d == SEND);
    dec    = go & (pend_q != '0);
    inc    = ev & ~(go & ~dec);
    pend_d = io.clear_i           ? '0 :
             (inc & ~dec)         ? ((pend_q == CNT_MAX) ? pend_q : pend_q + 1'b1) :
             (~inc & dec)         ? pend_q - 1'b1 : pend_q;
    ovf_d  = io.clear_i ? 1'b0 : (ovf_q | (inc & ~dec & (pend_q == CNT_MAX)));
  end
  // state, acknowledge history and sticky status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= io.ack_i;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end
  assign io.edge_o     = (state_q == SEND);
  assign io.busy_o     = (state_q != IDLE);
  assign io.pending_o  = pend_q;
  assign io.overflow_o = ovf_q;
  assign io.timeout_o  = to_q;
endmodule

// File: tb/tb_edge_event_throttle.sv
// tb_edge_event_throttle: randomized and directed stimulus checked against a queue-based behavioural model
module tb_edge_event_throttle;
  localparam int CW   = 2;
  localparam int MAXP = (1 << CW) - 1;
  localparam int TMO  = 8;
  typedef struct packed {
    logic          edge_v;
    logic          busy;
    logic [CW-1:0] pend;
    logic          ovf;
    logic          tmo;
  } exp_t;
  logic clk = 0;
  logic rst_i;
  edge_event_throttle_if #(.CNT_WIDTH(CW)) io ();
  edge_event_throttle #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .io(io.slave)
  );
  always #5 clk = ~clk;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dut_edges = 0;
  int   m_issues = 0;
  logic prev_edge = 0;
  bit   m_edge, m_wait, m_ovf, m_tmo, m_ackp;
  int   m_pend, m_wcnt;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  // monitor: every cycle the DUT presents its outputs, compare against the oldest prediction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("edge_o", int'(io.edge_o), int'(e.edge_v));
      chk("busy_o", int'(io.busy_o), int'(e.busy));
      chk("pending_o", int'(io.pending_o), int'(e.pend));
      chk("overflow_o", int'(io.overflow_o), int'(e.ovf));
      chk("timeout_o", int'(io.timeout_o), int'(e.tmo));
      if (io.edge_o === 1'b1) begin
        dut_edges++;
        chk("edge_not_back_to_back", int'(prev_edge), 0);
      end
      prev_edge = io.edge_o;
    end
  end
  // reference: events are a count of outstanding work; one crossing may be in flight at a time
  task automatic model(input bit r, input bit e, input bit c, input bit a);
    bit rise, eff, free, issue, expd, nwait;
    int total;
    if (r) begin
      m_edge = 0; m_wait = 0; m_pend = 0; m_ovf = 0; m_tmo = 0; m_wcnt = 0; m_ackp = 0;
    end else begin
      rise   = a && !m_ackp;
      m_ackp = a;
      eff    = e && !c;
      expd   = 0;
`ifdef EDGE_THROTTLE_TIMEOUT_EN
      expd   = m_wait && !rise && (m_wcnt == TMO - 1);
`endif
      free   = !m_edge && (!m_wait || rise);
      issue  = free && (eff || m_pend > 0);
      total  = m_pend + int'(eff) - int'(issue);
      if (c) begin
        total = 0; m_ovf = 0; m_tmo = 0;
      end else begin
        if (total > MAXP) begin
          total = MAXP;
          m_ovf = 1;
        end
        if (expd) m_tmo = 1;
      end
      nwait  = m_edge || (m_wait && !rise && !expd);
      m_wcnt = (m_wait && nwait) ? m_wcnt + 1 : 0;
      m_wait = nwait;
      m_edge = issue;
      m_pend = total;
      if (issue) m_issues++;
    end
    exp_q.push_back('{edge_v: m_edge, busy: m_edge || m_wait, pend: CW'(m_pend), ovf: m_ovf, tmo: m_tmo});
  endtask
  task automatic step(input bit r, input bit e, input bit c, input bit a);
    rst_i = r; io.event_i = e; io.clear_i = c; io.ack_i = a;
    @(posedge clk);
    model(r, e, c, a);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (!m_edge && !m_wait && m_pend == 0) break;
      step(0, 0, 0, i[0]);
    end
    step(0, 0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    idle(4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      idle(3);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
    drain();
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    idle(2);
    step(0, 0, 1, 0);
    idle(2);
    drain();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    idle(2);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    idle(2);
    drain();
`ifdef EDGE_THROTTLE_TIMEOUT_EN
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    idle(14);
    step(0, 0, 1, 0);
    drain();
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0);
    drain();
    @(negedge clk);
    @(negedge clk);
    chk("edge_count", dut_edges, m_issues);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_event_throttle.md
# edge_event_throttle

Single-clock upstream stage for the edge propagator with acknowledge. It accepts single-cycle event pulses from the transmit-domain logic and counts them, so no event is lost while a crossing is in flight. It then replays the events one at a time as `edge_o` pulses, issuing each only after the previous crossing's acknowledge returns. Events that arrive back-to-back, faster than the CDC round trip, are therefore queued rather than merged.

## Interface
Parameters:
- `CNT_WIDTH`, default 4: width of the pending-event counter. Maximum pending count is 2^CNT_WIDTH-1.
- `TIMEOUT_CYCLES`, default 256: WAIT_ACK watchdog limit. Used only when `EDGE_THROTTLE_TIMEOUT_EN` is defined. Must be ≥ 2.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `event_i` input 1: event pulse. Each high cycle is one event; consecutive high cycles are distinct events.
- `clear_i` input 1: synchronous clear of the pending count and `overflow_o`.
- `ack_i` input 1: acknowledge from the propagator's `ack_tx_o`. The rising edge is detected internally.
- `edge_o` output 1: single-cycle pulse to the propagator's `edge_i`.
- `busy_o` output 1: high when the FSM is not in IDLE.
- `pending_o` output CNT_WIDTH: number of queued events not yet issued.
- `overflow_o` output 1: sticky flag; an event was dropped because the counter was full.
- `timeout_o` output 1: sticky flag; the acknowledge watchdog expired.

## Operation
- Acknowledge edge detect:
  - `ack_q` register, reset value 0.
  - `ack_rise = ack_i & ~ack_q`.
  - `ack_rise` is ignored outside WAIT_ACK.
- FSM states are IDLE, SEND and WAIT_ACK. Reset state is IDLE.
  - **IDLE:** if `event_i` or `pending_q != 0`, go to SEND.
  - **SEND:** lasts one cycle, with `edge_o = 1`. Always goes to WAIT_ACK.
  - **WAIT_ACK:** on `ack_rise`:
    - go to SEND if `event_i` or `pending_q != 0`;
    - otherwise go to IDLE.
- Consumption: the transition into SEND consumes one event, either from `event_i` in that cycle or from the counter.
- Counter next value, per cycle:
  - +1 if `event_i` is not consumed by the current transition.
  - −1 if the transition into SEND consumes from the counter.
  - Unchanged when an incoming event and a consumption coincide: the incoming event is counted and the stored one is consumed, for a net 0.
  - The counter never wraps.
- Full: if `pending_q == 2^CNT_WIDTH-1` and an increment is required, the count holds, the event is dropped, and `overflow_o` is set from the next cycle.
- `clear_i`:
  - Next cycle: `pending_q = 0`, `overflow_o = 0`, `timeout_o = 0`.
  - An `event_i` in the same cycle is discarded.
  - FSM state is unaffected; an in-flight handshake completes normally.
- Reset mid-handshake: the FSM returns to IDLE and all state is cleared. The propagator must be reset together with this block.

## Timing
- Reset values: `edge_o = 0`, `busy_o = 0`, `pending_o = 0`, `overflow_o = 0`, `timeout_o = 0`, `ack_q = 0`.
- All outputs are registered or decoded directly from state: `edge_o = (state == SEND)`, `busy_o = (state != IDLE)`.
- Latency: `event_i` in IDLE at cycle n gives `edge_o` high at n+1. `pending_o` does not change for that event.
- Back-to-back: `ack_rise` at cycle m with work pending gives `edge_o` at m+1. The minimum spacing between `edge_o` pulses is therefore 2 cycles plus the acknowledge latency.
- `edge_o` is never high in two consecutive cycles.

## Configuration
- `EDGE_THROTTLE_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_ACK and is cleared on entry to WAIT_ACK.
  - If it reaches `TIMEOUT_CYCLES` without `ack_rise`, the FSM goes to IDLE and `timeout_o` is set sticky. It stays set until `clear_i` or reset.
  - The pending count is preserved, so issuing resumes from IDLE next cycle.
  - `ack_rise` and expiry in the same cycle: the acknowledge wins and `timeout_o` is not set.
- `EDGE_THROTTLE_TIMEOUT_EN` undefined: WAIT_ACK waits indefinitely, `timeout_o` is tied to 0, and no timeout counter is instantiated.

## Test plan
- **Reset:** assert `rst_i` for 3 cycles with `event_i = 1` → all outputs 0, FSM IDLE; the first event after release produces `edge_o` one cycle later.
- **Single event:** one event pulse, `ack_i` pulse 5 cycles after `edge_o` → exactly one `edge_o`, `busy_o` high for 6 cycles, `pending_o` stays 0.
- **Burst:** 4-cycle `event_i` burst, `ack_i` returned 4 cycles after each `edge_o` → `pending_o` reads 3, then 2, 1, 0; exactly 4 `edge_o` pulses, each one cycle after its `ack_rise`.
- **Overflow:** `CNT_WIDTH = 2`, 6 consecutive events, no ack → `pending_o = 3`, `overflow_o = 1`, one `edge_o` issued; `clear_i` → `pending_o = 0`, `overflow_o = 0`, FSM still in WAIT_ACK.
- **Simultaneous events:** `event_i` coincident with `ack_rise` while `pending_o = 2` → `edge_o` next cycle, `pending_o` stays 2.
- **Timeout (macro defined, `TIMEOUT_CYCLES = 8`):** `ack_i` held 0 → FSM returns to IDLE after 8 WAIT_ACK cycles, `timeout_o = 1`, and a queued event reissues `edge_o`.
